// File: rtl/ahb_ram_arbiter.sv
// Two-master AHB-Lite arbiter in front of a single zero-wait RAM slave; a losing address phase is
// buffered per master and replayed later. Define ARB_ROUND_ROBIN_EN for alternating NONSEQ priority.
module ahb_ram_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              M0_HSEL,
    input  logic [ADDR_W-1:0] M0_HADDR,
    input  logic [1:0]        M0_HTRANS,
    input  logic              M0_HWRITE,
    input  logic [2:0]        M0_HSIZE,
    input  logic [DATA_W-1:0] M0_HWDATA,
    input  logic              M0_HREADY,
    output logic              M0_HREADYOUT,
    output logic [DATA_W-1:0] M0_HRDATA,
    output logic [1:0]        M0_HRESP,
    input  logic              M1_HSEL,
    input  logic [ADDR_W-1:0] M1_HADDR,
    input  logic [1:0]        M1_HTRANS,
    input  logic              M1_HWRITE,
    input  logic [2:0]        M1_HSIZE,
    input  logic [DATA_W-1:0] M1_HWDATA,
    input  logic              M1_HREADY,
    output logic              M1_HREADYOUT,
    output logic [DATA_W-1:0] M1_HRDATA,
    output logic [1:0]        M1_HRESP,
    output logic              S_HSEL,
    output logic [ADDR_W-1:0] S_HADDR,
    output logic [1:0]        S_HTRANS,
    output logic              S_HWRITE,
    output logic [2:0]        S_HSIZE,
    output logic [DATA_W-1:0] S_HWDATA,
    output logic              S_HREADY,
    input  logic              S_HREADYOUT,
    input  logic [DATA_W-1:0] S_HRDATA
);
    localparam logic [1:0] TR_SEQ = 2'b11;

    typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} own_t;
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        trans;
        logic              write;
        logic [2:0]        size;
    } xfer_t;

    own_t  dp_own;
    xfer_t live0, live1, hold0, hold1, src0, src1;
    logic  pend0, pend1, live_req0, live_req1, req0, req1;
    logic  lock1, m1_first, gnt0, gnt1;

    assign live0 = {M0_HADDR, M0_HTRANS, M0_HWRITE, M0_HSIZE};
    assign live1 = {M1_HADDR, M1_HTRANS, M1_HWRITE, M1_HSIZE};

    // A stalled master sees HREADY=0, so its live inputs never race its own buffered transfer.
    assign live_req0 = M0_HSEL & M0_HTRANS[1] & M0_HREADY;
    assign live_req1 = M1_HSEL & M1_HTRANS[1] & M1_HREADY;
    assign req0      = pend0 | live_req0;
    assign req1      = pend1 | live_req1;
    assign src0      = pend0 ? hold0 : live0;
    assign src1      = pend1 ? hold1 : live1;

    assign lock1 = (dp_own == OWN_M1) && req1 && (src1.trans == TR_SEQ);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;  // 0: M0 granted last, 1: M1 granted last

    assign m1_first = ~last_grant;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            last_grant <= 1'b1;
        else if (S_HREADYOUT && (gnt0 || gnt1))
            last_grant <= gnt1;
    end
`else
    assign m1_first = 1'b0;
`endif

    assign gnt1 = req1 && (lock1 || !req0 || m1_first);
    assign gnt0 = req0 && !gnt1;

    always_comb begin
        S_HSEL   = 1'b0;
        S_HADDR  = '0;
        S_HTRANS = 2'b00;
        S_HWRITE = 1'b0;
        S_HSIZE  = 3'b000;
        if (gnt0) begin
            S_HSEL = 1'b1;
            {S_HADDR, S_HTRANS, S_HWRITE, S_HSIZE} = src0;
        end else if (gnt1) begin
            S_HSEL = 1'b1;
            {S_HADDR, S_HTRANS, S_HWRITE, S_HSIZE} = src1;
        end
    end

    always_comb begin
        case (dp_own)
            OWN_M0:  S_HWDATA = M0_HWDATA;
            OWN_M1:  S_HWDATA = M1_HWDATA;
            default: S_HWDATA = '0;
        endcase
    end

    assign S_HREADY     = S_HREADYOUT;
    assign M0_HRDATA    = S_HRDATA;
    assign M1_HRDATA    = S_HRDATA;
    assign M0_HRESP     = 2'b00;
    assign M1_HRESP     = 2'b00;
    assign M0_HREADYOUT = ~(pend0 | ((dp_own == OWN_M0) & ~S_HREADYOUT));
    assign M1_HREADYOUT = ~(pend1 | ((dp_own == OWN_M1) & ~S_HREADYOUT));

    // A live request that is not issued this edge is parked, including while the slave stalls.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_own <= OWN_NONE;
            pend0  <= 1'b0;
            pend1  <= 1'b0;
            hold0  <= '0;
            hold1  <= '0;
        end else begin
            if (S_HREADYOUT)
                dp_own <= gnt0 ? OWN_M0 : (gnt1 ? OWN_M1 : OWN_NONE);
            if (S_HREADYOUT && gnt0) begin
                pend0 <= 1'b0;
            end else if (live_req0) begin
                pend0 <= 1'b1;
                hold0 <= live0;
            end
            if (S_HREADYOUT && gnt1) begin
                pend1 <= 1'b0;
            end else if (live_req1) begin
                pend1 <= 1'b1;
                hold1 <= live1;
            end
        end
    end
endmodule

// File: tb/tb_ahb_ram_arbiter.sv
// Directed bench for ahb_ram_arbiter with a small zero-wait RAM model whose words reset to
// 0xA5000000 | byte address, so read data is known by hand.
module tb_ahb_ram_arbiter;
    logic        HCLK, HRESETn;
    logic        M0_HSEL, M0_HWRITE, M0_HREADYOUT;
    logic [31:0] M0_HADDR, M0_HWDATA, M0_HRDATA;
    logic [1:0]  M0_HTRANS, M0_HRESP;
    logic [2:0]  M0_HSIZE;
    logic        M1_HSEL, M1_HWRITE, M1_HREADYOUT;
    logic [31:0] M1_HADDR, M1_HWDATA, M1_HRDATA;
    logic [1:0]  M1_HTRANS, M1_HRESP;
    logic [2:0]  M1_HSIZE;
    logic        S_HSEL, S_HWRITE, S_HREADY;
    logic [31:0] S_HADDR, S_HWDATA, S_HRDATA;
    logic [1:0]  S_HTRANS;
    logic [2:0]  S_HSIZE;
    logic        s_ready;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int wr_count = 0;
    int wr_before;

    ahb_ram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .M0_HSEL(M0_HSEL), .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE),
        .M0_HSIZE(M0_HSIZE), .M0_HWDATA(M0_HWDATA), .M0_HREADY(M0_HREADYOUT),
        .M0_HREADYOUT(M0_HREADYOUT), .M0_HRDATA(M0_HRDATA), .M0_HRESP(M0_HRESP),
        .M1_HSEL(M1_HSEL), .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE),
        .M1_HSIZE(M1_HSIZE), .M1_HWDATA(M1_HWDATA), .M1_HREADY(M1_HREADYOUT),
        .M1_HREADYOUT(M1_HREADYOUT), .M1_HRDATA(M1_HRDATA), .M1_HRESP(M1_HRESP),
        .S_HSEL(S_HSEL), .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE),
        .S_HSIZE(S_HSIZE), .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY),
        .S_HREADYOUT(s_ready), .S_HRDATA(S_HRDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Zero-wait RAM slave: 256 words, address phase registered, write applied in the data phase.
    logic [31:0] mem [256];
    logic        wr_q;
    logic [7:0]  idx_q;
    logic [1:0]  lane_q;
    logic [2:0]  size_q;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | (i << 2);
            wr_q   <= 1'b0;
            idx_q  <= 8'd0;
            lane_q <= 2'd0;
            size_q <= 3'd0;
        end else begin
            if (wr_q) begin
                wr_count <= wr_count + 1;
                case (size_q)
                    3'b000:  mem[idx_q][lane_q*8 +: 8] <= S_HWDATA[lane_q*8 +: 8];
                    3'b001:  mem[idx_q][lane_q[1]*16 +: 16] <= S_HWDATA[lane_q[1]*16 +: 16];
                    default: mem[idx_q] <= S_HWDATA;
                endcase
            end
            if (S_HSEL && S_HTRANS[1] && S_HREADY) begin
                wr_q   <= S_HWRITE;
                idx_q  <= S_HADDR[9:2];
                lane_q <= S_HADDR[1:0];
                size_q <= S_HSIZE;
            end else begin
                wr_q <= 1'b0;
            end
        end
    end
    assign S_HRDATA = mem[idx_q];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m0(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                      input logic wr, input logic [2:0] sz);
        M0_HSEL = sel; M0_HTRANS = tr; M0_HADDR = a; M0_HWRITE = wr; M0_HSIZE = sz;
    endtask

    task automatic m1(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                      input logic wr, input logic [2:0] sz);
        M1_HSEL = sel; M1_HTRANS = tr; M1_HADDR = a; M1_HWRITE = wr; M1_HSIZE = sz;
    endtask

    task automatic idle_both;
        m0(1'b0, 2'b00, 32'h0, 1'b0, 3'b010);
        m1(1'b0, 2'b00, 32'h0, 1'b0, 3'b010);
    endtask

    task automatic do_reset;
        @(negedge HCLK);
        idle_both();
        HRESETn = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    initial begin
        HRESETn = 1'b0; s_ready = 1'b1;
        M0_HWDATA = 32'h0; M1_HWDATA = 32'h0;
        idle_both();
        #2;
        chk("rst_m0_rdy", 32'(M0_HREADYOUT), 1);
        chk("rst_m1_rdy", 32'(M1_HREADYOUT), 1);
        chk("rst_s_hsel", 32'(S_HSEL), 0);
        chk("rst_s_trans", 32'(S_HTRANS), 0);
        chk("rst_hresp", {28'h0, M0_HRESP, M1_HRESP}, 0);
        @(negedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;

        // write then read back through M0, uncontended
        @(negedge HCLK); m0(1, 2'b10, 32'h100, 1, 3'b010); #1;
        chk("t1_wr_sel", 32'(S_HSEL), 1);
        chk("t1_wr_addr", S_HADDR, 32'h100);
        chk("t1_wr_rdy", 32'(M0_HREADYOUT), 1);
        @(negedge HCLK); m0(1, 2'b10, 32'h100, 0, 3'b010); M0_HWDATA = 32'hDEAD_BEEF; #1;
        chk("t1_rd_sel", 32'(S_HSEL), 1);
        chk("t1_rd_write", 32'(S_HWRITE), 0);
        chk("t1_wdata", S_HWDATA, 32'hDEAD_BEEF);
        chk("t1_rd_rdy", 32'(M0_HREADYOUT), 1);
        @(negedge HCLK); idle_both(); #1;
        chk("t1_rdata", M0_HRDATA, 32'hDEAD_BEEF);
        chk("t1_dp_rdy", 32'(M0_HREADYOUT), 1);
        chk("t1_idle", {30'h0, S_HSEL, S_HTRANS[1]}, 0);

        // simultaneous NONSEQ reads: M0 first, M1 buffered one cycle
        do_reset();
        @(negedge HCLK); m0(1, 2'b10, 32'h10, 0, 3'b010); m1(1, 2'b10, 32'h20, 0, 3'b010); #1;
        chk("t2_n_addr", S_HADDR, 32'h10);
        chk("t2_n_m1rdy", 32'(M1_HREADYOUT), 1);
        @(negedge HCLK); idle_both(); #1;
        chk("t2_n1_addr", S_HADDR, 32'h20);
        chk("t2_n1_m1rdy", 32'(M1_HREADYOUT), 0);
        chk("t2_n1_m0data", M0_HRDATA, 32'hA500_0010);
        chk("t2_n1_m0rdy", 32'(M0_HREADYOUT), 1);
        @(negedge HCLK); #1;
        chk("t2_n2_m1rdy", 32'(M1_HREADYOUT), 1);
        chk("t2_n2_m1data", M1_HRDATA, 32'hA500_0020);

        // M1 locked INCR burst; M0 NONSEQ arrives at beat 2 and waits
        @(negedge HCLK); m1(1, 2'b10, 32'h40, 0, 3'b010); #1;
        chk("t3_b0", S_HADDR, 32'h40);
        @(negedge HCLK); m1(1, 2'b11, 32'h44, 0, 3'b010); m0(1, 2'b10, 32'h80, 0, 3'b010); #1;
        chk("t3_b1", S_HADDR, 32'h44);
        chk("t3_b1_m0rdy", 32'(M0_HREADYOUT), 1);
        chk("t3_b1_m1data", M1_HRDATA, 32'hA500_0040);
        @(negedge HCLK); m1(1, 2'b11, 32'h48, 0, 3'b010); m0(0, 2'b00, 32'h0, 0, 3'b010); #1;
        chk("t3_b2", S_HADDR, 32'h48);
        chk("t3_b2_m0rdy", 32'(M0_HREADYOUT), 0);
        @(negedge HCLK); m1(1, 2'b11, 32'h4C, 0, 3'b010); #1;
        chk("t3_b3", S_HADDR, 32'h4C);
        chk("t3_b3_trans", 32'(S_HTRANS), 3);
        @(negedge HCLK); idle_both(); #1;
        chk("t3_m0_addr", S_HADDR, 32'h80);
        chk("t3_m0_trans", 32'(S_HTRANS), 2);
        chk("t3_m0_pendrdy", 32'(M0_HREADYOUT), 0);
        chk("t3_b3_data", M1_HRDATA, 32'hA500_004C);
        @(negedge HCLK); #1;
        chk("t3_m0_rdy", 32'(M0_HREADYOUT), 1);
        chk("t3_m0_data", M0_HRDATA, 32'hA500_0080);
        chk("t3_idle", 32'(S_HSEL), 0);

        // reset while M1 holds a buffered write: the write must be dropped
        @(negedge HCLK); m0(1, 2'b10, 32'h30, 0, 3'b010); m1(1, 2'b10, 32'h34, 1, 3'b010); #1;
        chk("t4_addr", S_HADDR, 32'h30);
        chk("t4_m1rdy", 32'(M1_HREADYOUT), 1);
        @(negedge HCLK); idle_both(); M1_HWDATA = 32'h1234_5678; #1;
        chk("t4_pend_rdy", 32'(M1_HREADYOUT), 0);
        chk("t4_pend_addr", S_HADDR, 32'h34);
        wr_before = wr_count;
        #1 HRESETn = 1'b0;
        #1;
        chk("t4_rst_m1rdy", 32'(M1_HREADYOUT), 1);
        chk("t4_rst_trans", 32'(S_HTRANS), 0);
        @(negedge HCLK); HRESETn = 1'b1;
        @(negedge HCLK); #1;
        chk("t4_post_sel", 32'(S_HSEL), 0);
        chk("t4_post_rdy", {30'h0, M0_HREADYOUT, M1_HREADYOUT}, 3);
        chk("t4_no_write", 32'(wr_count), 32'(wr_before));
        @(negedge HCLK); m0(1, 2'b10, 32'h34, 0, 3'b010); #1;
        @(negedge HCLK); idle_both(); #1;
        chk("t4_mem_kept", M0_HRDATA, 32'hA500_0034);

        // BUSY/IDLE never issue; byte write lands in lane 3
        @(negedge HCLK); m0(1, 2'b01, 32'h50, 0, 3'b010); m1(1, 2'b00, 32'h54, 0, 3'b010); #1;
        chk("t5_busy_sel", 32'(S_HSEL), 0);
        chk("t5_busy_trans", 32'(S_HTRANS), 0);
        @(negedge HCLK); m0(1, 2'b10, 32'h103, 1, 3'b000); m1(1, 2'b01, 32'h58, 0, 3'b010); #1;
        chk("t5_byte_addr", S_HADDR, 32'h103);
        chk("t5_byte_size", 32'(S_HSIZE), 0);
        @(negedge HCLK); idle_both(); M0_HWDATA = 32'h5A00_0000; #1;
        chk("t5_idle_sel", 32'(S_HSEL), 0);
        chk("t5_wdata", S_HWDATA, 32'h5A00_0000);
        @(negedge HCLK); m0(1, 2'b10, 32'h100, 0, 3'b010); #1;
        @(negedge HCLK); idle_both(); #1;
        chk("t5_byte_merge", M0_HRDATA, 32'h5A00_0100);

        // both masters NONSEQ for six cycles
        do_reset();
        for (int k = 0; k < 6; k++) begin
            logic [31:0] exp_addr;
            logic        exp_m1rdy;
            @(negedge HCLK); m0(1, 2'b10, 32'h60, 0, 3'b010); m1(1, 2'b10, 32'h70, 0, 3'b010); #1;
`ifdef ARB_ROUND_ROBIN_EN
            exp_addr  = (k % 2 == 1) ? 32'h70 : 32'h60;
            exp_m1rdy = (k % 2 == 1) ? 1'b0 : 1'b1;
`else
            exp_addr  = 32'h60;
            exp_m1rdy = (k == 0) ? 1'b1 : 1'b0;
`endif
            chk($sformatf("t6_grant%0d", k), S_HADDR, exp_addr);
            chk($sformatf("t6_m1rdy%0d", k), 32'(M1_HREADYOUT), 32'(exp_m1rdy));
        end
        @(negedge HCLK); idle_both(); #1;
`ifdef ARB_ROUND_ROBIN_EN
        chk("t6_drain", S_HADDR, 32'h60);
`else
        chk("t6_drain", S_HADDR, 32'h70);
`endif
        @(negedge HCLK); #1;
        chk("t6_done_sel", 32'(S_HSEL), 0);
        @(negedge HCLK);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
